// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, issues single-outstanding fetches over a req/ready
// handshake, applies EX-stage redirects and presents the latched
// instruction with its decode fields.
// Optional build macro IF_MISALIGN_CHK_EN: a redirect to a target with
// bit 1 set is refused, fetch_misalign becomes sticky and the stage halts
// until reset. Without it, redirect targets are forced to word alignment.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  ex_pc_sel,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_func3,
  output logic [6:0]  id_func7,
  output logic        fetch_misalign
);

  localparam int unsigned XLEN   = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef IF_MISALIGN_CHK_EN
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;
`endif

  state_t          state;
  logic            req;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] skid;
  logic [XLEN-1:0] skid_pc;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;

  // Redirect decode and target computation from the EX stage
  always_comb begin
    redirect   = 1'b0;
    target_raw = ex_pc + ex_imm;
    case (ex_pc_sel)
      2'b00: redirect = ex_branch_taken;
      2'b01: redirect = 1'b1;
      2'b10: begin
        redirect   = 1'b1;
        target_raw = (ex_rs1 + ex_imm) & ~XLEN'(1);
      end
      default: redirect = 1'b0;
    endcase
  end

  assign target = target_raw & ~XLEN'(3);

`ifdef IF_MISALIGN_CHK_EN
  logic bad_target;
  logic misalign;
  assign bad_target     = redirect & target_raw[1];
  assign fetch_misalign = misalign;
`else
  assign fetch_misalign = 1'b0;
`endif

  assign imem_req  = req;
  assign imem_addr = pc;

  assign id_opcode = id_instr[6:0];
  assign id_func3  = id_instr[14:12];
  assign id_func7  = id_instr[31:25];

  // Fetch FSM, PC, skid buffer and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      req      <= 1'b0;
      pc       <= RESET_PC;
      pend_pc  <= RESET_PC;
      skid     <= NOP_INSTR;
      skid_pc  <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
      misalign <= 1'b0;
`endif
    end else begin
      // Flush invalidates IF/ID regardless of stall; later loads gate on it
      if (flush) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
`ifdef IF_MISALIGN_CHK_EN
      if (state != S_HALT && bad_target) begin
        state    <= S_HALT;
        req      <= 1'b0;
        misalign <= 1'b1;
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else
`endif
      case (state)
        S_FETCH: begin
          if (!req) begin
            // First cycle out of reset: no request outstanding yet
            req <= 1'b1;
            if (redirect) begin
              pc       <= target;
              id_valid <= 1'b0;
              id_instr <= NOP_INSTR;
            end
          end else if (imem_ready) begin
            if (redirect) begin
              pc       <= target;
              id_valid <= 1'b0;
              id_instr <= NOP_INSTR;
            end else if (!stall) begin
              if (!flush) begin
                id_instr <= imem_rdata;
                id_pc    <= pc;
                id_valid <= 1'b1;
              end
              pc <= pc + PC_STEP;
            end else begin
              skid    <= imem_rdata;
              skid_pc <= pc;
              pc      <= pc + PC_STEP;
              req     <= 1'b0;
              state   <= S_HOLD;
            end
          end else if (redirect) begin
            pend_pc  <= target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state    <= S_DRAIN;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc       <= target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            req      <= 1'b1;
            state    <= S_FETCH;
          end else if (!stall) begin
            if (!flush) begin
              id_instr <= skid;
              id_pc    <= skid_pc;
              id_valid <= 1'b1;
            end
            req   <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // Old request stays on the bus until accepted; its data is dropped
          if (imem_ready) begin
            pc    <= redirect ? target : pend_pc;
            state <= S_FETCH;
          end else if (redirect) begin
            pend_pc <= target;
          end
          if (redirect) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end

`ifdef IF_MISALIGN_CHK_EN
        S_HALT: begin
          req      <= 1'b0;
          id_valid <= 1'b0;
          id_instr <= NOP_INSTR;
        end
`endif

        default: begin
          req   <= 1'b1;
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a queue of expected IF/ID contents is filled
// by the stimulus and drained by an independent monitor.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  ex_pc_sel;
  logic        ex_branch_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
  logic [6:0]  id_func7;
  logic        fetch_misalign;

  logic        ovr_en;
  logic [31:0] ovr;

  int checks;
  int errors;
  exp_t sb[$];

  if_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .ex_pc_sel(ex_pc_sel),
    .ex_branch_taken(ex_branch_taken),
    .ex_pc(ex_pc),
    .ex_imm(ex_imm),
    .ex_rs1(ex_rs1),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_opcode(id_opcode),
    .id_func3(id_func3),
    .id_func7(id_func7),
    .fetch_misalign(fetch_misalign)
  );

  // Memory model: word depends on address unless overridden
  assign imem_rdata = ovr_en ? ovr : (32'hAB00_0000 | imem_addr);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] w);
    exp_t e;
    e.pc = p;
    e.instr = w;
    sb.push_back(e);
  endtask

  // Monitor: each newly presented valid IF/ID entry is checked against the queue
  logic        prev_valid;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (id_valid && (!prev_valid || id_pc != prev_pc || id_instr != prev_instr)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_id actual pc=%h instr=%h required none", id_pc, id_instr);
          end else begin
            e = sb.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_instr", id_instr, e.instr);
            chk("id_opcode", 32'(id_opcode), 32'(e.instr[6:0]));
            chk("id_func3", 32'(id_func3), 32'(e.instr[14:12]));
            chk("id_func7", 32'(id_func7), 32'(e.instr[31:25]));
          end
        end
        prev_valid = id_valid;
        prev_pc = id_pc;
        prev_instr = id_instr;
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_pc_sel = 2'b00; ex_branch_taken = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    imem_ready = 1'b0; ovr_en = 1'b0; ovr = '0;
    checks = 0; errors = 0;

    step; step;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    rst_n = 1'b1; imem_ready = 1'b1;
    step;
    chk("req_up", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0);
    chk("valid_first", 32'(id_valid), 32'd0);
    push(32'h0, 32'hAB00_0000);
    step;
    chk("addr4", imem_addr, 32'h4);
    chk("valid_second", 32'(id_valid), 32'd1);
    ovr_en = 1'b1; ovr = 32'h0050_0093; stall = 1'b1;
    push(32'h4, 32'h0050_0093);
    step;
    chk("hold_req", 32'(imem_req), 32'd0);
    ovr_en = 1'b0; imem_ready = 1'b0;
    step;
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_id_pc", id_pc, 32'h0);
    stall = 1'b0;
    step;
    chk("resume_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wait_addr8", imem_addr, 32'h8);
      chk("no_refresh", id_pc, 32'h4);
      if (i == 3) begin
        imem_ready = 1'b1;
        push(32'h8, 32'hAB00_0008);
      end
      step;
    end
    chk("addr12", imem_addr, 32'hC);
    imem_ready = 1'b0; ex_pc_sel = 2'b01; ex_pc = 32'h20; ex_imm = 32'h10;
    step;
    chk("drain_valid", 32'(id_valid), 32'd0);
    chk("drain_addr", imem_addr, 32'hC);
    chk("drain_req", 32'(imem_req), 32'd1);
    ex_pc_sel = 2'b00; imem_ready = 1'b1;
    step;
    chk("jal_addr", imem_addr, 32'h30);
    push(32'h30, 32'hAB00_0030);
    step;
    chk("addr34", imem_addr, 32'h34);
    ex_pc_sel = 2'b10; ex_rs1 = 32'h101; ex_imm = 32'h4;
    step;
    chk("jalr_addr", imem_addr, 32'h104);
    chk("jalr_valid", 32'(id_valid), 32'd0);
    ex_pc_sel = 2'b00;
    push(32'h104, 32'hAB00_0104);
    step;
    stall = 1'b1; flush = 1'b1; imem_ready = 1'b0;
    step;
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_instr", id_instr, 32'h0000_0013);
    chk("flush_opcode", 32'(id_opcode), 32'h13);
    chk("flush_addr", imem_addr, 32'h108);
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b1;
    ex_branch_taken = 1'b1; ex_pc = 32'h200; ex_imm = 32'hFFFF_FFF8;
    step;
    chk("branch_addr", imem_addr, 32'h1F8);
    ex_branch_taken = 1'b0; ex_pc_sel = 2'b11;
    push(32'h1F8, 32'hAB00_01F8);
    step;
    chk("sel11_addr", imem_addr, 32'h1FC);
    ex_pc_sel = 2'b01; ex_pc = 32'h40; ex_imm = 32'h2; imem_ready = 1'b0;
    step;
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_flag", 32'(fetch_misalign), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_valid", 32'(id_valid), 32'd0);
    ex_pc = 32'h80; ex_imm = 32'h0; imem_ready = 1'b1;
    step; step;
    chk("mis_sticky", 32'(fetch_misalign), 32'd1);
    chk("mis_req_hold", 32'(imem_req), 32'd0);
    ex_pc_sel = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("mis_rst_flag", 32'(fetch_misalign), 32'd0);
    chk("mis_rst_req", 32'(imem_req), 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("mis_restart_req", 32'(imem_req), 32'd1);
    chk("mis_restart_addr", imem_addr, 32'h0);
    imem_ready = 1'b0;
`else
    chk("nomis_flag", 32'(fetch_misalign), 32'd0);
    chk("nomis_req", 32'(imem_req), 32'd1);
    chk("nomis_drain_addr", imem_addr, 32'h1FC);
    ex_pc_sel = 2'b00; imem_ready = 1'b1;
    step;
    chk("align_addr", imem_addr, 32'h40);
    ex_pc_sel = 2'b01; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
    step;
    chk("wrap_addr", imem_addr, 32'h10);
    ex_pc = 32'h100; ex_imm = 32'h0; imem_ready = 1'b0;
    step;
    ex_pc_sel = 2'b10; ex_rs1 = 32'h300; ex_imm = 32'h0;
    step;
    ex_pc_sel = 2'b00; imem_ready = 1'b1;
    step;
    chk("latest_wins", imem_addr, 32'h300);
    imem_ready = 1'b0;
`endif
    step; step;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and issues fetches to instruction memory over a single-outstanding req/ready handshake.
- Applies EX-stage redirects: jal/branch go to pc+imm, jalr goes to rs1+imm.
- Presents the latched instruction and its opcode/func3/func7 fields to the decode controller.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction word shown on id_instr when no instruction is valid (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold IF/ID register and PC.
- flush  in  1  hazard unit: invalidate IF/ID register.
- ex_pc_sel  in  2  EX next-PC select: 00 sequential/branch, 01 pc+imm, 10 rs1+imm, 11 reserved.
- ex_branch_taken  in  1  EX branch compare result; only meaningful when ex_pc_sel=00.
- ex_pc  in  32  PC of the EX-stage instruction.
- ex_imm  in  32  sign-extended immediate of the EX-stage instruction.
- ex_rs1  in  32  rs1 operand of the EX-stage instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_rdata  in  32  fetch data, valid when imem_ready=1.
- imem_ready  in  1  fetch response/accept.
- id_valid  out  1  IF/ID holds a valid instruction.
- id_pc  out  32  PC of the IF/ID instruction.
- id_instr  out  32  IF/ID instruction word.
- id_opcode  out  7  id_instr[6:0].
- id_func3  out  3  id_instr[14:12].
- id_func7  out  7  id_instr[31:25].
- fetch_misalign  out  1  misaligned-target flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values (asynchronous):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0 while rst_n=0.
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR.
  - Skid buffer empty, fetch_misalign=0.
- The id_* field outputs are pure slices of id_instr.
- Redirect:
  - redirect = (ex_pc_sel==01) | (ex_pc_sel==00 & ex_branch_taken) | (ex_pc_sel==10).
  - target = ex_pc+ex_imm for sel 00/01; (ex_rs1+ex_imm) & ~32'h1 for sel 10.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is not detected.
  - Sel 11 is never a redirect.
- Handshake:
  - Out of reset, imem_req=1 with imem_addr=pc.
  - imem_req and imem_addr are held stable until a cycle with imem_ready=1; a transfer completes in that cycle.
  - One outstanding request at most. Minimum latency is 1 cycle (ready in the same cycle as req).
- State FETCH (imem_req=1):
  - ready & redirect: discard data, pc<=target, id_valid<=0, stay in FETCH.
  - ready & !stall: id_instr<=imem_rdata, id_pc<=pc, id_valid<=!flush, pc<=pc+4.
  - ready & stall: skid<=imem_rdata, skid_pc<=pc, pc<=pc+4, go to HOLD.
  - !ready & redirect: pend_pc<=target, id_valid<=0, go to DRAIN.
- State HOLD (imem_req=0):
  - !stall: IF/ID<=skid, id_valid<=!flush, go to FETCH.
  - redirect: drop skid, pc<=target, id_valid<=0, go to FETCH. Redirect takes priority over stall release.
- State DRAIN (imem_req=1, old address held):
  - A new redirect overwrites pend_pc (latest wins).
  - On ready: data is discarded, pc<=pend_pc (or the new target if a redirect arrives that same cycle), go to FETCH.
- Priority on the IF/ID register: redirect > flush > stall > load.
  - flush clears id_valid next cycle and sets id_instr=NOP_INSTR even when stall=1.
  - Stall with id_valid=0 still holds (no bubble filling).
- rst_n assertion mid-transaction abandons any outstanding request. The memory must tolerate req dropping.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - A redirect whose target[1]=1 is not taken.
  - fetch_misalign sets and is sticky until reset.
  - state goes to HALT (imem_req=0, id_valid=0), and all further redirects are ignored.
- Not defined:
  - target[1:0] is forced to 00 before use.
  - fetch_misalign is constant 0, and HALT does not exist.

Test Plan:
- Reset, ready tied 1 with incrementing data -> imem_addr 0,4,8,…; id_pc lags imem_addr by 1 cycle; id_valid=1 from the second clock after reset release.
- Ready delayed 3 cycles on addr 8 -> imem_addr holds 8 for 4 cycles and id_valid is not refreshed; resumes at 12.
- stall=1 for 2 cycles when ready returns 0x00500093 at pc 4 -> state HOLD, imem_req=0; after release id_instr=0x00500093, id_pc=4, next fetch addr 8.
- ex_pc=0x20, ex_imm=0x10, sel 01 while ready=0 -> DRAIN; old response discarded, id_valid=0; next imem_addr=0x30.
- sel 10, ex_rs1=0x101, ex_imm=0x4 -> next imem_addr=0x104; flush and stall together -> id_valid=0, id_instr=0x00000013.
- With IF_MISALIGN_CHK_EN: sel 01, ex_pc=0x40, ex_imm=0x2 -> fetch_misalign=1, imem_req=0 until rst_n pulse.
